dma_arg_fetch: RTL
==================

Name: dma_arg_fetch

Overview:
- Argument-fetch engine upstream of the ecdsa compute datapath (Montgomery multiplier, EC add).
- Reads the argument-pointer table over the DMA RX channel, dereferences each pointer, and presents up to MAX_ARGC 381-bit operands as one flat vector.
- Frees the top-level command FSM from address muxing and per-argument counting.

Parameters:
- MAX_ARGC, 4, max arguments fetched per command; legal range 1..11, since one 381-bit table beat holds 11 pointers.
- DATA_W, 381, operand width; equals DMA payload width.
- ADDR_W, 32, DMA address width.

Ports:
- clk  in  1  system clock
- resetn  in  1  async active-low reset
- start  in  1  level request; accepted in IDLE only
- table_base  in  ADDR_W  address of the pointer table; sampled on accept
- argc  in  32  argument count; sampled on accept
- busy  out  1  high from accept until DONE/ERR
- done  out  1  high in DONE
- error  out  1  high in ERR
- args  out  MAX_ARGC*DATA_W  operand i at [i*DATA_W +: DATA_W]
- arg_loaded  out  MAX_ARGC  bit i set once operand i is written
- dma_rx_address  out  ADDR_W  DMA read address
- dma_rx_start  out  1  one-cycle DMA read pulse
- dma_rx_data  in  DATA_W  DMA read payload (MSB-aligned)
- dma_done  in  1  DMA transfer complete
- dma_idle  in  1  DMA ready to accept a request
- dma_error  in  1  DMA fault

Behaviour:
- Reset (async, resetn=0), all outputs 0:
  - state=IDLE; busy, done, error, dma_rx_start = 0.
  - dma_rx_address, args, arg_loaded = 0.
  - Reset mid-transfer aborts immediately. There is no DMA cancel; any later stale dma_done is ignored in IDLE.
- States: IDLE, TBL_REQ, TBL_WAIT, VAL_REQ, VAL_WAIT, DONE, ERR.
- IDLE:
  - start=1 → accept: latch table_base and argc, clear args and arg_loaded, idx=0, busy=1.
  - argc==0 → DONE, no DMA issued.
  - argc>MAX_ARGC → ERR, no DMA issued.
  - Otherwise → TBL_REQ.
- TBL_REQ/VAL_REQ:
  - Wait while dma_idle=0.
  - When dma_idle=1, at the next edge:
    - dma_rx_start=1 for exactly one cycle.
    - dma_rx_address = table_base (TBL) or ptr[idx] (VAL).
    - Go to the matching WAIT state.
  - Address and start are registered together, so the address is stable while start is high.
- TBL_WAIT/VAL_WAIT:
  - dma_done is ignored in the first WAIT cycle (guard against stale done).
  - dma_error=1 in any WAIT cycle → ERR. Error takes priority over a simultaneous dma_done.
- TBL_WAIT on dma_done:
  - Latch pointer table: ptr[i] = dma_rx_data[DATA_W-1-32*i -: 32], i < MAX_ARGC.
  - → VAL_REQ.
- VAL_WAIT on dma_done:
  - args[idx] = dma_rx_data; arg_loaded[idx]=1.
  - If idx==argc-1 → DONE; else idx+1 → VAL_REQ.
- DONE: done=1, busy=0. Stay until start=0, then → IDLE. args is held unchanged until the next accept.
- ERR: error=1, busy=0. Stay until start=0, then → IDLE. Partially loaded args and arg_loaded remain visible for debug.
- start held high through DONE/ERR never retriggers; start must drop for ≥1 cycle.
- Latency with dma_idle=1 and dma_done D cycles after start (D≥2): accept→done = 1 + (argc+1)*(D+1) + 1 cycles.
- idx is 4 bits; it is compared against the latched argc truncated-safe, because argc≤MAX_ARGC is checked at accept.

Optional Feature:
- Macro DMA_ARG_FETCH_ALIGN_CHECK_EN.
- Defined:
  - table_base is checked at accept: bits [6:0] ≠ 0 → ERR with no DMA.
  - Each ptr[idx] is checked in VAL_REQ before issue: bits [6:0] ≠ 0 → ERR with no DMA issued.
  - The check enforces 128-byte alignment of the 1024-bit AXI beat.
- Undefined: no alignment check; any address is issued as-is.

Test Plan:
1. MAX_ARGC=4, argc=3, table_base=0x1000, pointers 0x2000/0x2080/0x2100, data 381'hA/381'hB/381'h1F, dma_done 5 cycles after start → exactly 4 rx_start pulses at addresses 0x1000, 0x2000, 0x2080, 0x2100; args[0]=A, [1]=B, [2]=1F; arg_loaded=4'b0111; done after 1+4*6+1=26 cycles.
2. argc=0 with start=1 → done=1 next cycle, zero rx_start pulses; start held high 10 cycles → no retrigger; start=0 → IDLE.
3. argc=5 → error=1 next cycle, no DMA; then argc=2 with start toggled → normal completion.
4. dma_error=1 coincident with dma_done on the 2nd value fetch → ERR, arg_loaded=4'b0001, args[1] unchanged (0).
5. dma_idle held 0 for 20 cycles in TBL_REQ → no rx_start until idle rises, then exactly one pulse; resetn pulsed low during VAL_WAIT → all outputs 0 asynchronously, and a later dma_done is ignored.
6. With DMA_ARG_FETCH_ALIGN_CHECK_EN: ptr[1]=0x2040 → ERR after value 0 is loaded, only 2 rx_start pulses. Same stimulus without the macro → 3 pulses, done=1.

Source files
------------

// File: rtl/dma_arg_fetch.sv
// ---------------------------------------------------------------------------
// dma_arg_fetch
//
// Argument-fetch engine that sits in front of the ecdsa compute datapath.
// On a command it reads the argument-pointer table with one DMA RX transfer,
// then dereferences each pointer with one more transfer per argument and
// presents the operands as a single flat vector.
//
// Optional feature (compile-time macro DMA_ARG_FETCH_ALIGN_CHECK_EN):
//   when defined, table_base and every pointer must be 128-byte aligned
//   (bits [6:0] == 0); a misaligned address ends the command in ERR without
//   issuing the corresponding DMA request.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              level request, accepted in IDLE only
//   table_base, argc   command arguments, sampled on accept
//   busy/done/error    command status (busy until DONE or ERR)
//   args               operand i at [i*DATA_W +: DATA_W]
//   arg_loaded         bit i set once operand i has been written
//   dma_rx_address     DMA read address, stable while dma_rx_start is high
//   dma_rx_start       one-cycle DMA read request pulse
//   dma_rx_data        DMA read payload (MSB-aligned)
//   dma_done           DMA transfer complete
//   dma_idle           DMA ready to accept a request
//   dma_error          DMA fault
// ---------------------------------------------------------------------------
module dma_arg_fetch #(
   parameter int MAX_ARGC = 4,    // 1..11: one table beat holds 11 pointers
   parameter int DATA_W   = 381,
   parameter int ADDR_W   = 32
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       start,
   input  logic [ADDR_W-1:0]          table_base,
   input  logic [31:0]                argc,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [MAX_ARGC*DATA_W-1:0] args,
   output logic [MAX_ARGC-1:0]        arg_loaded,
   output logic [ADDR_W-1:0]          dma_rx_address,
   output logic                       dma_rx_start,
   input  logic [DATA_W-1:0]          dma_rx_data,
   input  logic                       dma_done,
   input  logic                       dma_idle,
   input  logic                       dma_error
);

   localparam int IDX_W = 4;
   localparam int PTR_W = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TBL_REQ,
      S_TBL_WAIT,
      S_VAL_REQ,
      S_VAL_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    argc_q;
   logic [ADDR_W-1:0]   base_q;
   logic [PTR_W-1:0]    ptr_q [MAX_ARGC];
   logic [DATA_W-1:0]   arg_q [MAX_ARGC];
   logic [MAX_ARGC-1:0] loaded_q;
   logic                rx_start_q;
   logic [ADDR_W-1:0]   rx_addr_q;

   // Control strobes from the FSM to the datapath.
   logic accept, issue_tbl, issue_val, load_tbl, load_val;

   logic [PTR_W-1:0] ptr_sel;
   logic             argc_zero, argc_over, last_arg;
   logic             base_bad, ptr_bad;

   // Pointer for the current argument, selected by idx.
   always_comb begin
      ptr_sel = '0;
      for (int i = 0; i < MAX_ARGC; i++) begin
         if (idx_q == IDX_W'(i)) ptr_sel = ptr_q[i];
      end
   end

   assign argc_zero = (argc == 32'd0);
   assign argc_over = (argc > 32'(MAX_ARGC));
   // argc_q is never 0 while fetching values, so argc_q-1 cannot wrap.
   assign last_arg  = (idx_q == argc_q - IDX_W'(1));

`ifdef DMA_ARG_FETCH_ALIGN_CHECK_EN
   assign base_bad = (table_base[6:0] != 7'd0);
   assign ptr_bad  = (ptr_sel[6:0] != 7'd0);
`else
   assign base_bad = 1'b0;
   assign ptr_bad  = 1'b0;
`endif

   // FSM next-state and control strobes.
   // NOTE: every signal written here gets a default first, so no path
   // through the case statement can leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      issue_tbl = 1'b0;
      issue_val = 1'b0;
      load_tbl  = 1'b0;
      load_val  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               accept = 1'b1;
               if (argc_zero)                 state_d = S_DONE;
               else if (argc_over || base_bad) state_d = S_ERR;
               else                           state_d = S_TBL_REQ;
            end
         end
         S_TBL_REQ: begin
            if (dma_idle) begin
               issue_tbl = 1'b1;
               state_d   = S_TBL_WAIT;
            end
         end
         // rx_start_q is high exactly in the first WAIT cycle, which is the
         // cycle in which a stale dma_done from earlier traffic must be ignored.
         S_TBL_WAIT: begin
            if (dma_error) begin
               state_d = S_ERR;
            end else if (dma_done && !rx_start_q) begin
               load_tbl = 1'b1;
               state_d  = S_VAL_REQ;
            end
         end
         S_VAL_REQ: begin
            if (ptr_bad) begin
               state_d = S_ERR;
            end else if (dma_idle) begin
               issue_val = 1'b1;
               state_d   = S_VAL_WAIT;
            end
         end
         S_VAL_WAIT: begin
            if (dma_error) begin
               state_d = S_ERR;
            end else if (dma_done && !rx_start_q) begin
               load_val = 1'b1;
               state_d  = last_arg ? S_DONE : S_VAL_REQ;
            end
         end
         S_DONE, S_ERR: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Datapath. The operand and pointer arrays are reset as well: the outputs
   // must read zero from reset, and the arrays are only MAX_ARGC entries deep.
   // NOTE: reset of the operand storage is deliberate here; a large RAM-style
   // array would normally be left unreset and qualified by a valid bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_q      <= '0;
         argc_q     <= '0;
         base_q     <= '0;
         loaded_q   <= '0;
         rx_start_q <= 1'b0;
         rx_addr_q  <= '0;
         for (int i = 0; i < MAX_ARGC; i++) begin
            ptr_q[i] <= '0;
            arg_q[i] <= '0;
         end
      end else begin
         rx_start_q <= issue_tbl | issue_val;

         if (accept) begin
            base_q   <= table_base;
            argc_q   <= argc[IDX_W-1:0];   // only used when argc <= MAX_ARGC
            idx_q    <= '0;
            loaded_q <= '0;
            for (int i = 0; i < MAX_ARGC; i++) arg_q[i] <= '0;
         end

         if (issue_tbl) rx_addr_q <= base_q;
         if (issue_val) rx_addr_q <= ADDR_W'(ptr_sel);

         if (load_tbl) begin
            for (int i = 0; i < MAX_ARGC; i++) begin
               ptr_q[i] <= dma_rx_data[DATA_W-1-PTR_W*i -: PTR_W];
            end
         end

         if (load_val) begin
            for (int i = 0; i < MAX_ARGC; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  arg_q[i]    <= dma_rx_data;
                  loaded_q[i] <= 1'b1;
               end
            end
            if (!last_arg) idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   for (genvar g = 0; g < MAX_ARGC; g++) begin : g_args
      assign args[g*DATA_W +: DATA_W] = arg_q[g];
   end

   assign arg_loaded     = loaded_q;
   assign dma_rx_start   = rx_start_q;
   assign dma_rx_address = rx_addr_q;
   assign busy  = (state_q == S_TBL_REQ) || (state_q == S_TBL_WAIT) ||
                  (state_q == S_VAL_REQ) || (state_q == S_VAL_WAIT);
   assign done  = (state_q == S_DONE);
   assign error = (state_q == S_ERR);

endmodule
